// File: rtl/sram_burst_ctrl.sv
// Burst read/write controller for a single-port 128x2048 SRAM macro.
// Issues one access per cycle and tracks the macro's fixed read/write latency with a 2-stage pipe.
module sram_burst_ctrl #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned LEN_W  = 11
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              sram_CEN,
    output logic              sram_WEN,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    input  logic [DATA_W-1:0] sram_Q
);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        drain_q, drain_d;

    logic              issue;
    logic              issue_wr;

    logic              s1_valid_q, s1_write_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s2_valid_q, s2_write_q;
    logic [DATA_W-1:0] s2_data_q;

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_write ? StWr : StRd;
                end
            end
            StRd: begin
                addr_d = addr_q + ADDR_W'(1);
                if (cnt_q == '0) begin
                    state_d = StDrain;
                    drain_d = 2'd1;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            StWr: begin
                if (wr_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (cnt_q == '0) begin
                        state_d = StDrain;
                        drain_d = 2'd2;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            StDrain: begin
                if (drain_q == 2'd1) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; cmd_ready is held low for as long as reset is asserted
    always_comb begin
        cmd_ready = (state_q == StIdle) & ~reset;
        wr_ready  = (state_q == StWr);
        issue_wr  = (state_q == StWr);
        issue     = (state_q == StRd) | ((state_q == StWr) & wr_valid);
        done      = (state_q == StDrain) & (drain_q == 2'd1);
        sram_CEN  = ~issue;
        sram_A    = issue ? addr_q : '0;
    end

    // Free-running access pipeline, shifted every cycle like the macro's own CEN pipeline
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_write_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_write_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= issue;
            s1_write_q <= issue & issue_wr;
            s1_data_q  <= (issue & issue_wr) ? wr_data : '0;
            s2_valid_q <= s1_valid_q;
            s2_write_q <= s1_write_q;
            s2_data_q  <= s1_data_q;
        end
    end

    always_comb begin
        sram_WEN = s2_valid_q & s2_write_q;
        sram_D   = s2_valid_q ? s2_data_q : '0;
        rd_valid = s1_valid_q & ~s1_write_q;
        rd_data  = sram_Q;
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Randomized bench for sram_burst_ctrl: behavioural SRAM macro plus a burst-level reference
// model that predicts every output cycle by cycle.
module tb_sram_burst_ctrl;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 128;
    localparam int LEN_W  = 11;
    localparam int DEPTH  = 2048;
    localparam int RING   = 4;

    logic              CLK = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_valid, wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid, done;
    logic [DATA_W-1:0] rd_data;
    logic              sram_CEN, sram_WEN;
    logic [ADDR_W-1:0] sram_A;
    logic [DATA_W-1:0] sram_D;
    logic [DATA_W-1:0] sram_Q = '0;

    always #5 CLK = ~CLK;

    sram_burst_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .done     (done),
        .sram_CEN (sram_CEN),
        .sram_WEN (sram_WEN),
        .sram_A   (sram_A),
        .sram_D   (sram_D),
        .sram_Q   (sram_Q)
    );

    function automatic logic [DATA_W-1:0] seed_word(input int i);
        logic [31:0] w;
        w = 32'(i) * 32'h9E37_79B1;
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
    endfunction

    // Behavioural macro: read data one cycle after issue, write committed with WEN two cycles later
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] a_p1 = '0, a_p2 = '0;
    logic              mem_init = 1'b0;

    always @(posedge CLK) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
            mem_init <= 1'b1;
        end else begin
            if (!sram_CEN) sram_Q <= mem[sram_A];
            if (sram_WEN) mem[a_p2] <= sram_D;
        end
        a_p1 <= sram_A;
        a_p2 <= a_p1;
    end

    // Checking
    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: memory contents and a short ring of events scheduled into future cycles
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                r_rdv  [RING];
    logic [DATA_W-1:0] r_rdd  [RING];
    bit                r_wen  [RING];
    logic [ADDR_W-1:0] r_wa   [RING];
    logic [DATA_W-1:0] r_wd   [RING];
    bit                r_done [RING];

    bit                m_busy, m_active, m_pending, m_write, m_accept, m_took;
    logic [ADDR_W-1:0] m_addr;
    int                m_left, m_free_at;

    logic [DATA_W-1:0] wq [$];

    task automatic clear_slot(input int s);
        r_rdv[s]  = 1'b0;
        r_rdd[s]  = '0;
        r_wen[s]  = 1'b0;
        r_wa[s]   = '0;
        r_wd[s]   = '0;
        r_done[s] = 1'b0;
    endtask

    task automatic eval_cycle();
        int                s, s2, lat;
        bit                e_ready, e_wrr, e_cen, e_wen, e_rdv, e_done;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_d, e_rdd;
        s = cyc % RING;
        e_ready = 1'b0; e_wrr = 1'b0; e_cen = 1'b1; e_a = '0;
        e_wen = 1'b0; e_d = '0; e_rdv = 1'b0; e_rdd = '0; e_done = 1'b0;
        if (reset) begin
            for (int i = 0; i < RING; i++) clear_slot(i);
            m_busy = 1'b0; m_active = 1'b0; m_pending = 1'b0;
            m_took = 1'b0; m_accept = 1'b0;
        end else begin
            e_wen  = r_wen[s];
            e_d    = r_wd[s];
            e_rdv  = r_rdv[s];
            e_rdd  = r_rdd[s];
            e_done = r_done[s];
            if (r_wen[s]) ref_mem[r_wa[s]] = r_wd[s];
            clear_slot(s);
            if (m_pending) begin
                m_pending = 1'b0;
                m_active  = 1'b1;
            end
            if (m_busy && !m_active && cyc >= m_free_at) m_busy = 1'b0;
            e_ready = !m_busy;
            e_wrr   = m_active && m_write;
            if (m_active && (!m_write || wr_valid)) begin
                lat   = m_write ? 2 : 1;
                e_cen = 1'b0;
                e_a   = m_addr;
                s2    = (cyc + lat) % RING;
                if (m_write) begin
                    r_wen[s2] = 1'b1;
                    r_wa[s2]  = m_addr;
                    r_wd[s2]  = wr_data;
                    m_took    = 1'b1;
                end else begin
                    r_rdv[s2] = 1'b1;
                    r_rdd[s2] = ref_mem[m_addr];
                end
                m_addr = m_addr + 11'd1;
                if (m_left == 0) begin
                    m_active   = 1'b0;
                    r_done[s2] = 1'b1;
                    m_free_at  = cyc + lat + 1;
                end else begin
                    m_left--;
                end
            end
            if (!m_busy && cmd_valid) begin
                m_busy    = 1'b1;
                m_pending = 1'b1;
                m_accept  = 1'b1;
                m_write   = cmd_write;
                m_addr    = cmd_addr;
                m_left    = int'(cmd_len);
            end
        end
        check("cmd_ready", DATA_W'(cmd_ready), DATA_W'(e_ready));
        check("wr_ready", DATA_W'(wr_ready), DATA_W'(e_wrr));
        check("sram_CEN", DATA_W'(sram_CEN), DATA_W'(e_cen));
        if (!e_cen || reset) check("sram_A", DATA_W'(sram_A), DATA_W'(e_a));
        check("sram_WEN", DATA_W'(sram_WEN), DATA_W'(e_wen));
        check("sram_D", sram_D, e_d);
        check("rd_valid", DATA_W'(rd_valid), DATA_W'(e_rdv));
        if (e_rdv) check("rd_data", rd_data, e_rdd);
        check("done", DATA_W'(done), DATA_W'(e_done));
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled on negedge
    task automatic tick();
        @(negedge CLK);
        eval_cycle();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_burst(input bit wr, input int addr, input int len, input int gap_pct,
                             input bit gap_once, input bit seq_data, input int abort_at);
        int guard, took, limit;
        bit gapped;
        wq.delete();
        if (wr) begin
            for (int k = 0; k <= len; k++) begin
                if (seq_data) wq.push_back(DATA_W'(32'hA0 + k));
                else wq.push_back({$urandom, $urandom, $urandom, $urandom});
            end
        end
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = ADDR_W'(addr);
        cmd_len   = LEN_W'(len);
        wr_valid  = wr;
        wr_data   = wr ? wq[0] : '0;
        m_accept  = 1'b0;
        guard     = 0;
        while (!m_accept && guard < 64) begin
            tick();
            guard++;
        end
        check("cmd_accept_bound", DATA_W'(m_accept), DATA_W'(1));
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = ADDR_W'($urandom);
        cmd_len   = LEN_W'($urandom);
        guard  = 0;
        took   = 0;
        gapped = 1'b0;
        limit  = 10 * (len + 1) + 16;
        while ((m_pending || m_active) && guard < limit) begin
            tick();
            guard++;
            if (abort_at > 0 && guard == abort_at) begin
                reset    = 1'b1;
                wr_valid = 1'b0;
                wq.delete();
                tick();
                tick();
                reset = 1'b0;
                return;
            end
            if (m_took) begin
                m_took = 1'b0;
                wq.delete(0);
                took++;
            end
            if (wq.size() > 0) begin
                if (gap_once && took == 1 && !gapped) begin
                    wr_valid = 1'b0;
                    gapped   = 1'b1;
                end else begin
                    wr_valid = ($urandom_range(0, 99) >= gap_pct);
                end
                wr_data = wq[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = '0;
            end
        end
        check("burst_bound", DATA_W'(m_pending || m_active), DATA_W'(0));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        for (int i = 0; i < RING; i++) clear_slot(i);
        m_busy = 1'b0; m_active = 1'b0; m_pending = 1'b0; m_write = 1'b0;
        m_accept = 1'b0; m_took = 1'b0; m_addr = '0; m_left = 0; m_free_at = 0;
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0;
        @(posedge CLK);
        #1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Directed: sequential write/read, wrap with a gap, length 0, and two mid-burst resets
        run_burst(1'b1, 5, 3, 0, 1'b0, 1'b1, 0);
        run_burst(1'b0, 5, 3, 0, 1'b0, 1'b0, 0);
        run_burst(1'b1, 2046, 2, 0, 1'b1, 1'b0, 0);
        run_burst(1'b0, 2046, 2, 0, 1'b0, 1'b0, 0);
        run_burst(1'b0, 7, 0, 0, 1'b0, 1'b0, 0);
        run_burst(1'b1, 40, 3, 0, 1'b0, 1'b0, 2);
        run_burst(1'b0, 40, 3, 0, 1'b0, 1'b0, 0);
        run_burst(1'b1, 40, 3, 0, 1'b0, 1'b0, 3);
        run_burst(1'b0, 40, 3, 0, 1'b0, 1'b0, 0);
        run_burst(1'b1, 60, 0, 0, 1'b0, 1'b0, 0);
        run_burst(1'b0, 60, 0, 0, 1'b0, 1'b0, 0);

        // Random bursts in a small window straddling the address wrap
        for (int b = 0; b < 200; b++) begin
            int addr, len, abort;
            addr  = (2040 + int'($urandom_range(0, 23))) % DEPTH;
            len   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40))
                                                : int'($urandom_range(0, 7));
            abort = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : 0;
            run_burst(1'($urandom_range(0, 1)), addr, len, 30, 1'b0, 1'b0, abort);
        end
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
